fifo_rd_stream: RTL and testbench

Read-side stream adapter placed directly downstream of `async_fifo`, in the read clock domain. It pops words from the FIFO's `rinc`/`rdata`/`rempty` port and presents them on a registered valid/ready master stream. A two-entry output buffer sustains one word per cycle under continuous `m_ready` and absorbs back-pressure without losing data.

---
 rtl/fifo_rd_stream_pkg.sv | 11 +
 rtl/fifo_rd_stream.sv | 90 +++++++++
 tb/tb_fifo_rd_stream.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: occupancy state encoding and parameter defaults for fifo_rd_stream.
package fifo_rd_stream_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    localparam int DSIZE_DEF = 32;
    localparam int CNTW_DEF  = 16;
endpackage

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops async_fifo read port into a two-entry registered valid/ready stream.
// Define FIFO_RD_STREAM_CNT_EN to enable the accepted-transfer counter on m_count.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             flush,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic [CNTW-1:0]  m_count
);
    occ_state_t       state_q, state_d;
    logic [DSIZE-1:0] main_q, main_d;
    logic [DSIZE-1:0] skid_q, skid_d;
    logic             push, pop;

    // rrst_n gates the pop so the FIFO is never drained while held in reset
    assign rinc    = rrst_n & ~rempty & ~flush & (state_q != TWO);
    assign m_valid = (state_q != EMPTY);
    assign m_data  = main_q;
    assign push    = rinc;
    assign pop     = m_valid & m_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    main_d  = rdata;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    main_d = rdata;
                end else if (push) begin
                    skid_d  = rdata;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = cnt_q + CNTW'(pop);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign m_count = cnt_q;
`else
    assign m_count = '0;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench with a queue-based FIFO model driving fifo_rd_stream (CNTW=4).
module tb_fifo_rd_stream;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          flush = 1'b0;
    logic          rempty = 1'b1;
    logic [DW-1:0] rdata = '0;
    logic          rinc;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_count;

    logic [DW-1:0] fifo[$];
    logic [DW-1:0] got[$];
    logic          gate = 1'b0;
    logic          rinc_s = 1'b0;
    logic          hs_s = 1'b0;
    logic [DW-1:0] dat_s = '0;
    int            cnt_exp = 0;
    int            total = 0;
    int            bad = 0;
    logic          prev;
    logic [DW-1:0] dummy;

    fifo_rd_stream #(.DSIZE(DW), .CNTW(CW)) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .flush   (flush),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_count (m_count)
    );

    always #5 rclk = ~rclk;

    // sample DUT outputs mid-cycle so edge-time updates never race the model
    always @(negedge rclk) begin
        rinc_s = rinc;
        hs_s   = m_valid && m_ready;
        dat_s  = m_data;
    end

    always @(posedge rclk) if (rinc_s && fifo.size() > 0) dummy = fifo.pop_front();

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic upd();
        rempty = gate || (fifo.size() == 0);
        rdata  = (fifo.size() > 0) ? fifo[0] : '0;
    endtask

    task automatic step();
        @(posedge rclk);
        if (hs_s) begin
            got.push_back(dat_s);
            cnt_exp++;
        end
        #1;
        upd();
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("count", 64'(m_count), 64'(cnt_exp % 16));
`else
        chk("count", 64'(m_count), 64'd0);
`endif
    endtask

    initial begin
        fifo.push_back(32'h55);
        upd();
        m_ready = 1'b1;
        repeat (2) @(posedge rclk);
        #1;
        chk("rst_rinc", 64'(rinc), 64'd0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_count", 64'(m_count), 64'd0);
        rrst_n = 1'b1;
        #1;
        chk("rel_rinc", 64'(rinc), 64'd1);
        step();
        chk("first_word", {31'd0, m_valid, m_data}, {31'd0, 1'b1, 32'h55});
        step();
        chk("first_drain", 64'(m_valid), 64'd0);

        got.delete();
        for (int i = 0; i < 20; i++) fifo.push_back(DW'(i));
        upd();
        for (int i = 0; i < 20; i++) begin
            step();
            chk("stream", {31'd0, m_valid, m_data}, {31'd0, 1'b1, 32'(i)});
        end
        step();
        chk("stream_end", 64'(m_valid), 64'd0);
        chk("stream_n", 64'(got.size()), 64'd20);

        m_ready = 1'b0;
        fifo.push_back(32'hA);
        fifo.push_back(32'hB);
        fifo.push_back(32'hC);
        fifo.push_back(32'hD);
        upd();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold", {31'd0, m_valid, m_data}, {31'd0, 1'b1, 32'hA});
        end
        chk("bp_pops", 64'(fifo.size()), 64'd2);
        chk("bp_rinc", 64'(rinc), 64'd0);
        m_ready = 1'b1;
        step();
        chk("bp_b", 64'(m_data), 64'hB);
        step();
        chk("bp_c", 64'(m_data), 64'hC);
        step();
        chk("bp_d", 64'(m_data), 64'hD);
        step();
        chk("bp_end", 64'(m_valid), 64'd0);

        got.delete();
        for (int i = 0; i < 4; i++) fifo.push_back(32'h31 + DW'(i));
        for (int i = 0; i < 9; i++) begin
            gate = (i % 2 == 1);
            upd();
            #1;
            prev = rinc;
            step();
            chk("il_latency", 64'(m_valid), 64'(prev));
        end
        gate = 1'b0;
        upd();
        chk("il_n", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("il_word", 64'(got[i]), 64'(32'h31 + i));

        m_ready = 1'b0;
        fifo.push_back(32'h1);
        fifo.push_back(32'h2);
        fifo.push_back(32'h3);
        upd();
        step();
        step();
        chk("fl_main", 64'(m_data), 64'h1);
        flush = 1'b1;
        #1;
        chk("fl_rinc_two", 64'(rinc), 64'd0);
        step();
        flush = 1'b0;
        #1;
        chk("fl_valid", 64'(m_valid), 64'd0);
        chk("fl_rinc_after", 64'(rinc), 64'd1);
        m_ready = 1'b1;
        step();
        chk("fl_next", {31'd0, m_valid, m_data}, {31'd0, 1'b1, 32'h3});
        step();
        chk("fl_drain", 64'(m_valid), 64'd0);

        fifo.push_back(32'h4);
        fifo.push_back(32'h5);
        upd();
        step();
        chk("fl1_main", 64'(m_data), 64'h4);
        flush = 1'b1;
        #1;
        chk("fl1_rinc", 64'(rinc), 64'd0);
        step();
        flush = 1'b0;
        #1;
        chk("fl1_valid", 64'(m_valid), 64'd0);
        chk("fl1_left", 64'(fifo.size()), 64'd1);
        step();
        chk("fl1_next", {31'd0, m_valid, m_data}, {31'd0, 1'b1, 32'h5});
        step();

        m_ready = 1'b0;
        fifo.push_back(32'h6);
        upd();
        step();
        chk("ar_pre", {31'd0, m_valid, m_data}, {31'd0, 1'b1, 32'h6});
        #2;
        rrst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(m_valid), 64'd0);
        chk("ar_data", 64'(m_data), 64'd0);
        chk("ar_count", 64'(m_count), 64'd0);
        chk("ar_rinc", 64'(rinc), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
